// File: rtl/hough_pkg.sv
// Shared types, constants and width helpers for the Hough pixel pipeline overlay stages.
package hough_pkg;

   localparam int LINE_OVL_LATENCY = 3;

   localparam int DEF_PIX_W   = 8;
   localparam int DEF_COORD_W = 10;
   localparam int DEF_FRAC_W  = 4;
   localparam int DEF_THICK_W = 3;

   function automatic int slope_w(input int coord_w, input int frac_w);
      return coord_w + frac_w + 1;
   endfunction

   // Full-precision m*x: signed slope times zero-extended (hence +1) coordinate.
   function automatic int prod_w(input int coord_w, input int frac_w);
      return slope_w(coord_w, frac_w) + coord_w + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic                                           en;
      logic signed [slope_w(DEF_COORD_W, DEF_FRAC_W)-1:0] m;
      logic signed [DEF_COORD_W:0]                    c;
      logic [DEF_THICK_W-1:0]                         tol;
      logic [DEF_PIX_W-1:0]                           colour;
   } line_cfg_t;

endpackage

// File: rtl/line_eval.sv
// One overlay line channel: registers m*x (stage 2), then floors, adds c and
// compares |y - yl| against the thickness tolerance (stage 3, combinational hit).
module line_eval
   import hough_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int FRAC_W  = DEF_FRAC_W,
   parameter int THICK_W = DEF_THICK_W,
   localparam int M_W    = slope_w(COORD_W, FRAC_W),
   localparam int P_W    = prod_w(COORD_W, FRAC_W)
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               en,
   input  logic [M_W-1:0]     m,
   input  logic [COORD_W:0]   c,
   input  logic [THICK_W-1:0] tol,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic               hit
);

   localparam int E_W = P_W + 2;

   logic signed [P_W-1:0]   prod_q;
   logic signed [COORD_W:0] c_q;
   logic [COORD_W-1:0]      y_q;
   logic [THICK_W-1:0]      tol_q;
   logic                    en_q;
   logic signed [E_W-1:0]   yl, dy, ady;

   // c/tol/en travel with the product so a commit cannot split a beat across two sets.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         prod_q <= '0;
         c_q    <= '0;
         y_q    <= '0;
         tol_q  <= '0;
         en_q   <= 1'b0;
      end else begin
         prod_q <= P_W'($signed(m)) * P_W'($signed({1'b0, x}));
         c_q    <= c;
         y_q    <= y;
         tol_q  <= tol;
         en_q   <= en;
      end
   end

   always_comb begin
      yl  = E_W'(prod_q >>> FRAC_W) + E_W'(c_q);
      dy  = E_W'($signed({1'b0, y_q})) - yl;
      ady = dy[E_W-1] ? -dy : dy;
      hit = en_q && (ady <= E_W'($signed({1'b0, tol_q})));
   end

endmodule

// File: rtl/line_overlay.sv
// Line-drawing overlay: raster coordinate tracking, shadow/active line config
// committed on FrameIn, NLINES line channels and a lowest-index-wins colour mux.
module line_overlay
   import hough_pkg::*;
#(
   parameter int PIX_W   = DEF_PIX_W,
   parameter int COORD_W = DEF_COORD_W,
   parameter int NLINES  = 4,
   parameter int FRAC_W  = DEF_FRAC_W,
   parameter int THICK_W = DEF_THICK_W,
   localparam int M_W    = slope_w(COORD_W, FRAC_W),
   localparam int IDX_W  = idx_w(NLINES)
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               ValidIn,
   input  logic [PIX_W-1:0]   PixelIn,
   input  logic               FrameIn,
   input  logic               LineIn,
   output logic               ValidOut,
   output logic [PIX_W-1:0]   PixelOut,
   output logic               FrameOut,
   output logic               LineOut,
   input  logic               CfgValid,
   output logic               CfgReady,
   input  logic [IDX_W-1:0]   CfgIdx,
   input  logic               CfgEn,
   input  logic [M_W-1:0]     CfgM,
   input  logic [COORD_W:0]   CfgC,
   input  logic [THICK_W-1:0] CfgTol,
   input  logic [PIX_W-1:0]   CfgColour
);

   localparam int                 LAT       = LINE_OVL_LATENCY;
   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   logic                cfg_ready_q, cfg_wr, commit;
   logic [NLINES-1:0]   sh_en, act_en, hit;
   logic [M_W-1:0]      sh_m [NLINES];
   logic [M_W-1:0]      act_m [NLINES];
   logic [COORD_W:0]    sh_c [NLINES];
   logic [COORD_W:0]    act_c [NLINES];
   logic [THICK_W-1:0]  sh_tol [NLINES];
   logic [THICK_W-1:0]  act_tol [NLINES];
   logic [PIX_W-1:0]    sh_col [NLINES];
   logic [PIX_W-1:0]    act_col [NLINES];
   logic [PIX_W-1:0]    col2_q [NLINES];
   logic [COORD_W-1:0]  x_q, y_q, x_d, y_d;
   logic [PIX_W-1:0]    pix1_q, pix2_q, pix_mux;
   logic [2:0]          ctl_q [LAT];

   assign cfg_wr   = CfgValid && cfg_ready_q && (32'(CfgIdx) < NLINES);
   assign commit   = ValidIn && FrameIn;
   assign CfgReady = cfg_ready_q;
   assign ValidOut = ctl_q[LAT-1][2];
   assign FrameOut = ctl_q[LAT-1][1];
   assign LineOut  = ctl_q[LAT-1][0];

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (ValidIn) begin
         if (FrameIn) begin
            x_d = '0;
            y_d = '0;
         end else if (LineIn) begin
            x_d = '0;
            if (y_q != COORD_MAX) y_d = y_q + 1'b1;
         end else if (x_q != COORD_MAX) begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Commit samples the shadow before this cycle's write lands in it.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         cfg_ready_q <= 1'b0;
         sh_en       <= '0;
         act_en      <= '0;
         for (int i = 0; i < NLINES; i++) begin
            sh_m[i]    <= '0;
            act_m[i]   <= '0;
            sh_c[i]    <= '0;
            act_c[i]   <= '0;
            sh_tol[i]  <= '0;
            act_tol[i] <= '0;
            sh_col[i]  <= '0;
            act_col[i] <= '0;
         end
      end else begin
         cfg_ready_q <= 1'b1;
         if (commit) begin
            act_en  <= sh_en;
            act_m   <= sh_m;
            act_c   <= sh_c;
            act_tol <= sh_tol;
            act_col <= sh_col;
         end
         if (cfg_wr) begin
            sh_en[CfgIdx]  <= CfgEn;
            sh_m[CfgIdx]   <= CfgM;
            sh_c[CfgIdx]   <= CfgC;
            sh_tol[CfgIdx] <= CfgTol;
            sh_col[CfgIdx] <= CfgColour;
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         x_q      <= '0;
         y_q      <= '0;
         pix1_q   <= '0;
         pix2_q   <= '0;
         PixelOut <= '0;
         for (int i = 0; i < LAT; i++) ctl_q[i] <= '0;
         for (int i = 0; i < NLINES; i++) col2_q[i] <= '0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         pix1_q   <= PixelIn;
         pix2_q   <= pix1_q;
         ctl_q[0] <= {ValidIn, ValidIn && FrameIn, ValidIn && LineIn};
         for (int i = 1; i < LAT; i++) ctl_q[i] <= ctl_q[i-1];
         col2_q   <= act_col;
         PixelOut <= ctl_q[LAT-2][2] ? pix_mux : '0;
      end
   end

   always_comb begin
      pix_mux = pix2_q;
      for (int i = NLINES - 1; i >= 0; i--) begin
         if (hit[i]) pix_mux = col2_q[i];
      end
   end

   for (genvar g = 0; g < NLINES; g++) begin : g_line
      line_eval #(
         .COORD_W (COORD_W),
         .FRAC_W  (FRAC_W),
         .THICK_W (THICK_W)
      ) u_eval (
         .Clk    (Clk),
         .nReset (nReset),
         .en     (act_en[g]),
         .m      (act_m[g]),
         .c      (act_c[g]),
         .tol    (act_tol[g]),
         .x      (x_q),
         .y      (y_q),
         .hit    (hit[g])
      );
   end

endmodule

// File: tb/tb_line_overlay.sv
// Directed bench for line_overlay: reference model feeds a scoreboard queue that is
// drained LINE_OVL_LATENCY cycles later, plus spot checks on captured frames.
module tb_line_overlay;
   import hough_pkg::*;

   logic        Clk, nReset;
   logic        ValidIn, FrameIn, LineIn;
   logic [7:0]  PixelIn;
   logic        ValidOut, FrameOut, LineOut;
   logic [7:0]  PixelOut;
   logic        CfgValid, CfgReady, CfgEn;
   logic [1:0]  CfgIdx;
   logic [14:0] CfgM;
   logic [10:0] CfgC;
   logic [2:0]  CfgTol;
   logic [7:0]  CfgColour;

   line_overlay dut (
      .Clk(Clk), .nReset(nReset), .ValidIn(ValidIn), .PixelIn(PixelIn),
      .FrameIn(FrameIn), .LineIn(LineIn), .ValidOut(ValidOut), .PixelOut(PixelOut),
      .FrameOut(FrameOut), .LineOut(LineOut), .CfgValid(CfgValid), .CfgReady(CfgReady),
      .CfgIdx(CfgIdx), .CfgEn(CfgEn), .CfgM(CfgM), .CfgC(CfgC), .CfgTol(CfgTol),
      .CfgColour(CfgColour)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit         valid;
      bit         frame;
      bit         line;
      logic [7:0] pix;
      int         x;
      int         y;
   } exp_t;

   exp_t       sbq[$];
   line_cfg_t  sh[4];
   line_cfg_t  act[4];
   line_cfg_t  wr_cfg;
   bit         wr_pend;
   int         wr_idx;
   int         mx, my;
   int         checks, errors;
   logic [7:0] obs[16][16];
   logic [7:0] hit_col;
   int         hit_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic line_cfg_t mk(input bit en, input int m, input int c, input int tol,
                                    input logic [7:0] col);
      line_cfg_t r;
      r.en     = en;
      r.m      = 15'(m);
      r.c      = 11'(c);
      r.tol    = 3'(tol);
      r.colour = col;
      return r;
   endfunction

   function automatic logic [7:0] model_pix(input int x, input int y, input logic [7:0] pin);
      longint yl, d;
      for (int i = 0; i < 4; i++) begin
         if (act[i].en) begin
            yl = ((longint'(act[i].m) * longint'(x)) >>> 4) + longint'(act[i].c);
            d  = longint'(y) - yl;
            if (d < 0) d = -d;
            if (d <= longint'(act[i].tol)) return act[i].colour;
         end
      end
      return pin;
   endfunction

   task automatic cfg_set(input int idx, input line_cfg_t c);
      CfgValid  = 1'b1;
      CfgIdx    = 2'(idx);
      CfgEn     = c.en;
      CfgM      = c.m;
      CfgC      = c.c;
      CfgTol    = c.tol;
      CfgColour = c.colour;
      wr_pend   = 1'b1;
      wr_idx    = idx;
      wr_cfg    = c;
   endtask

   task automatic check_out(input exp_t e);
      chk("valid_out", 32'(ValidOut), 32'(e.valid));
      chk("frame_out", 32'(FrameOut), 32'(e.frame));
      chk("line_out",  32'(LineOut),  32'(e.line));
      chk("pixel_out", 32'(PixelOut), 32'(e.pix));
      if (e.valid && e.x < 16 && e.y < 16) obs[e.x][e.y] = PixelOut;
      if (e.valid && PixelOut === hit_col) hit_cnt++;
   endtask

   task automatic step(input bit v, input bit f, input bit l, input logic [7:0] p);
      exp_t e;
      ValidIn = v;
      FrameIn = f;
      LineIn  = l;
      PixelIn = p;
      if (v) begin
         if (f) begin
            mx = 0;
            my = 0;
            for (int i = 0; i < 4; i++) act[i] = sh[i];
         end else if (l) begin
            mx = 0;
            if (my < 1023) my++;
         end else if (mx < 1023) begin
            mx++;
         end
      end
      if (wr_pend) begin
         chk("cfg_ready", 32'(CfgReady), 32'd1);
         sh[wr_idx] = wr_cfg;
         wr_pend    = 1'b0;
      end
      e.valid = v;
      e.frame = v && f;
      e.line  = v && l;
      e.pix   = v ? model_pix(mx, my, p) : 8'h00;
      e.x     = mx;
      e.y     = my;
      sbq.push_back(e);
      @(posedge Clk);
      #1;
      CfgValid = 1'b0;
      if (sbq.size() >= LINE_OVL_LATENCY) check_out(sbq.pop_front());
   endtask

   task automatic frame(input int w, input int h, input bit gaps, input bit fl_both,
                        input int wr_beat, input int wi, input line_cfg_t wc);
      int beat;
      beat    = 0;
      hit_cnt = 0;
      foreach (obs[i, j]) obs[i][j] = 8'h00;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (beat == wr_beat) cfg_set(wi, wc);
            step(1'b1, x == 0 && y == 0, (x == 0 && y > 0) || (fl_both && x == 0 && y == 0), 8'h10);
            beat++;
            if (gaps && beat % 2 == 0) step(1'b0, 1'b0, 1'b0, 8'hEE);
         end
      end
      for (int i = 0; i < LINE_OVL_LATENCY; i++) step(1'b0, 1'b0, 1'b0, 8'hEE);
   endtask

   task automatic write_now(input int idx, input line_cfg_t c);
      cfg_set(idx, c);
      step(1'b0, 1'b0, 1'b0, 8'hEE);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         sh[i]  = '0;
         act[i] = '0;
      end
      mx = 0;
      my = 0;
      wr_pend = 1'b0;
      sbq.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, 32'(ValidOut), 32'd0);
      chk({tag, "_pixel"}, 32'(PixelOut), 32'd0);
      chk({tag, "_frame"}, 32'(FrameOut), 32'd0);
      chk({tag, "_line"},  32'(LineOut),  32'd0);
      chk({tag, "_ready"}, 32'(CfgReady), 32'd0);
   endtask

   line_cfg_t none;

   initial begin
      checks = 0;
      errors = 0;
      none   = '0;
      nReset = 1'b0;
      {ValidIn, FrameIn, LineIn, PixelIn} = '0;
      {CfgValid, CfgIdx, CfgEn, CfgM, CfgC, CfgTol, CfgColour} = '0;
      hit_col = 8'h00;
      model_reset();
      #1;
      check_outputs_zero("reset");
      @(posedge Clk); @(posedge Clk); #1;
      nReset = 1'b1;
      @(posedge Clk); #1;
      chk("ready_after_reset", 32'(CfgReady), 32'd1);

      // diagonal m=1.0
      write_now(0, mk(1, 16, 0, 0, 8'h3C));
      hit_col = 8'h3C;
      frame(16, 16, 0, 0, -1, 0, none);
      chk("diag_count", 32'(hit_cnt), 32'd16);
      chk("diag_5_5", 32'(obs[5][5]), 32'h3C);
      chk("diag_5_6", 32'(obs[5][6]), 32'h10);

      // m=-0.5, c=7
      write_now(0, mk(1, -8, 7, 0, 8'hC3));
      hit_col = 8'hC3;
      frame(8, 8, 0, 0, -1, 0, none);
      chk("neg_count", 32'(hit_cnt), 32'd8);
      chk("neg_3_5", 32'(obs[3][5]), 32'hC3);
      chk("neg_3_4", 32'(obs[3][4]), 32'h10);
      chk("neg_3_6", 32'(obs[3][6]), 32'h10);
      write_now(0, mk(1, -8, 7, 1, 8'hC3));
      frame(8, 8, 0, 0, -1, 0, none);
      chk("tol1_count", 32'(hit_cnt), 32'd23);
      chk("tol1_3_4", 32'(obs[3][4]), 32'hC3);
      chk("tol1_3_5", 32'(obs[3][5]), 32'hC3);
      chk("tol1_3_6", 32'(obs[3][6]), 32'hC3);
      chk("tol1_3_3", 32'(obs[3][3]), 32'h10);
      chk("tol1_3_7", 32'(obs[3][7]), 32'h10);

      // priority between lines 0 and 2
      write_now(0, mk(1, 16, 0, 0, 8'hAA));
      write_now(2, mk(1, 0, 4, 0, 8'h55));
      hit_col = 8'h55;
      frame(8, 8, 0, 0, -1, 0, none);
      chk("prio_4_4", 32'(obs[4][4]), 32'hAA);
      chk("prio_2_4", 32'(obs[2][4]), 32'h55);
      chk("prio_2_2", 32'(obs[2][2]), 32'hAA);
      write_now(0, mk(0, 16, 0, 0, 8'hAA));
      frame(8, 8, 0, 0, -1, 0, none);
      chk("dis0_4_4", 32'(obs[4][4]), 32'h55);
      chk("dis0_2_2", 32'(obs[2][2]), 32'h10);

      // mid-frame and same-cycle-as-FrameIn writes
      frame(8, 8, 0, 0, 20, 1, mk(1, 0, 6, 0, 8'h77));
      chk("mid_wr_same_frame", 32'(obs[0][6]), 32'h10);
      frame(8, 8, 0, 0, 0, 1, mk(0, 0, 6, 0, 8'h77));
      chk("mid_wr_next_frame", 32'(obs[0][6]), 32'h77);
      frame(8, 8, 0, 0, -1, 0, none);
      chk("sof_wr_next_frame", 32'(obs[0][6]), 32'h10);

      // valid gaps, FrameIn with LineIn
      frame(8, 8, 1, 1, -1, 0, none);
      chk("gap_count", 32'(hit_cnt), 32'd8);
      chk("gap_3_4", 32'(obs[3][4]), 32'h55);
      chk("gap_3_5", 32'(obs[3][5]), 32'h10);

      // reset mid-frame
      step(1'b1, 1'b1, 1'b0, 8'h10);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h10);
      #2;
      nReset  = 1'b0;
      ValidIn = 1'b0;
      FrameIn = 1'b0;
      LineIn  = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      model_reset();
      @(posedge Clk); @(posedge Clk); #1;
      nReset = 1'b1;
      @(posedge Clk); #1;
      chk("ready_after_mid_reset", 32'(CfgReady), 32'd1);
      frame(8, 8, 0, 0, -1, 0, none);
      chk("post_reset_count", 32'(hit_cnt), 32'd0);
      chk("post_reset_3_4", 32'(obs[3][4]), 32'h10);
      frame(8, 8, 0, 0, 10, 2, mk(1, 0, 4, 0, 8'h55));
      chk("post_reset_uncommitted", 32'(hit_cnt), 32'd0);
      frame(8, 8, 0, 0, -1, 0, none);
      chk("post_reset_committed", 32'(hit_cnt), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_overlay.md
# line_overlay

Parametrised line-drawing overlay for the Hough pixel pipeline. It tracks raster coordinates from the frame/line markers and evaluates up to NLINES lines of the form y = m·x + c, with signed fixed-point slope, signed intercept and per-line thickness. It replaces hit pixels with a per-line colour and passes all other pixels through unchanged, after a fixed pipeline delay. It sits after the accumulator/peak stages and draws detected lines onto the video stream; line parameters are loaded through a handshake and take effect only at frame boundaries.

## Interface
- PIX_W, 8, pixel width
- COORD_W, 10, unsigned x/y coordinate width
- NLINES, 4, number of line channels (≥1)
- FRAC_W, 4, fractional bits of slope m
- THICK_W, 3, thickness tolerance width
- Clk  in  1  clock
- nReset  in  1  reset, asynchronous, active-low
- ValidIn  in  1  pixel qualifier; markers and pixel ignored when low
- PixelIn  in  PIX_W  input pixel
- FrameIn  in  1  first pixel of frame
- LineIn  in  1  first pixel of a new line
- ValidOut  out  1  delayed ValidIn
- PixelOut  out  PIX_W  overlaid pixel
- FrameOut  out  1  delayed FrameIn
- LineOut  out  1  delayed LineIn
- CfgValid  in  1  config write request
- CfgReady  out  1  config accept
- CfgIdx  in  clog2(NLINES)  target line
- CfgEn  in  1  line enable
- CfgM  in  COORD_W+FRAC_W+1  signed slope, FRAC_W fractional bits
- CfgC  in  COORD_W+1  signed intercept
- CfgTol  in  THICK_W  allowed |dy|
- CfgColour  in  PIX_W  draw colour

## Operation
- Coordinates are computed per valid beat:
  - FrameIn → (0,0).
  - Else LineIn → x=0, y=y_prev+1.
  - Else x=x_prev+1.
  - FrameIn has priority over LineIn.
  - x and y saturate at 2^COORD_W−1; they do not wrap.
  - Coordinates hold while ValidIn=0.
- Before the first FrameIn after reset, coordinates start from (0,0).
- Config writes:
  - A write occurs when CfgValid&CfgReady; CfgReady is always 1 after reset.
  - A write updates the shadow set for CfgIdx.
  - CfgIdx ≥ NLINES is accepted and discarded.
- Commit: the shadow set is copied to the active set on a valid beat with FrameIn=1. That frame and all later frames use the new set.
  - If a write and a commit occur in the same cycle, the commit takes the old shadow value. The write appears from the following frame.
- Evaluation per enabled line i:
  - yl = (m·x) >>> FRAC_W + c. The shift is arithmetic (floor).
  - Full-precision signed arithmetic; no truncation before the compare.
  - Hit when |y − yl| ≤ Tol. Tol=0 means exact match only.
- Output:
  - If any line hits, PixelOut = colour of the lowest-index hitting line.
  - Otherwise PixelOut = PixelIn.
  - Disabled lines never hit.

## Timing
- Fixed latency of 3 cycles from the input beat to the output beat, for pixel, markers and valid alike.
  - Stage 1: coordinate update.
  - Stage 2: m·x products.
  - Stage 3: add, compare, priority mux.
- The pipeline advances every cycle; there is no backpressure. Invalid beats propagate with ValidOut=0, and PixelOut is then don't-care (driven 0).
- Reset values:
  - All outputs 0; CfgReady=0 during reset, 1 from the first clock after release.
  - Coordinates 0.
  - Active and shadow sets all 0, so lines are disabled.
- If reset is asserted mid-frame, the pipeline clears at once. Nothing is drawn until config has been written and a FrameIn commits it.

## Structure
- Shared package hough_pkg holds:
  - a line_cfg_t struct (en, m, c, tol, colour);
  - a LINE_OVL_LATENCY=3 constant;
  - width helper functions.
- Sub-module line_eval holds one channel's stage-2/3 arithmetic and hit flag, and is instantiated NLINES times.
- The top level holds coordinates, config registers, the pipeline delay and the priority mux.

## Test plan
- One line enabled, m=1.0 (CfgM=16), c=0, Tol=0, 16×16 frame of PixelIn=0x10 → PixelOut=CfgColour exactly on the diagonal, 0x10 elsewhere, 3-cycle latency.
- m=−0.5 (CfgM=−8), c=7, x=3: yl=floor(−1.5)+7=5 → hit at y=5 only. Repeat with Tol=1 → hits at y=4,5,6.
- Lines 0 and 2 both hit pixel (4,4) with colours 0xAA and 0x55 → 0xAA output; disable line 0 → 0x55.
- Write line 1 mid-frame → no change until the next FrameIn. Write in the same cycle as the FrameIn beat → takes effect one frame later.
- ValidIn gaps every 3rd cycle → coordinates hold, hits unchanged, ValidOut mirrors ValidIn delayed by 3. FrameIn&LineIn together → (0,0).
- Assert nReset mid-frame → all outputs 0 immediately; after release, passthrough with no overlay until config is written and a FrameIn commits it.
